// File: rtl/mcb_sig_pipe_if.sv
// ---------------------------------------------------------------------------
// mcb_sig_pipe_if
// Bundles the request side (sequencer -> pipe) and the SDRAM pin side
// (pipe -> pads) of the mcb_sig_pipe command/address output stage.
//   slave  : view of mcb_sig_pipe (requests in, pins out)
//   master : view of the sequencer / pad model (requests out, pins in)
// Signals:
//   mcb_sclr_n, mcb_bb, mcb_ba, mcb_ra, mcb_ca   clear + address latch
//   i_prea, i_ref, i_lmr, i_emr                 init requests
//   c_ref..c_wr, c_pde, c_pdx, c_sre, c_srx     run-time / power requests
//   sdr_cke..sdr_addr                           registered SDRAM pins
//   cke_st, err_cmd                             status
// ---------------------------------------------------------------------------
interface mcb_sig_pipe_if #(
    parameter int unsigned MCB_B_W = 2,
    parameter int unsigned MCB_R_W = 13,
    parameter int unsigned MCB_C_W = 9,
    parameter int unsigned SDR_B_W = 2,
    parameter int unsigned SDR_A_W = 13
);
    logic               mcb_sclr_n;
    logic               mcb_bb;
    logic [MCB_B_W-1:0] mcb_ba;
    logic [MCB_R_W-1:0] mcb_ra;
    logic [MCB_C_W-1:0] mcb_ca;
    logic               i_prea, i_ref, i_lmr, i_emr;
    logic               c_ref, c_act, c_pre, c_rda, c_rd, c_wra, c_wr;
    logic               c_pde, c_pdx, c_sre, c_srx;
    logic               sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [SDR_B_W-1:0] sdr_ba;
    logic [SDR_A_W-1:0] sdr_addr;
    logic [1:0]         cke_st;
    logic               err_cmd;

    modport slave (
        input  mcb_sclr_n, mcb_bb, mcb_ba, mcb_ra, mcb_ca,
        input  i_prea, i_ref, i_lmr, i_emr,
        input  c_ref, c_act, c_pre, c_rda, c_rd, c_wra, c_wr,
        input  c_pde, c_pdx, c_sre, c_srx,
        output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
        output sdr_ba, sdr_addr, cke_st, err_cmd
    );

    modport master (
        output mcb_sclr_n, mcb_bb, mcb_ba, mcb_ra, mcb_ca,
        output i_prea, i_ref, i_lmr, i_emr,
        output c_ref, c_act, c_pre, c_rda, c_rd, c_wra, c_wr,
        output c_pde, c_pdx, c_sre, c_srx,
        input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
        input  sdr_ba, sdr_addr, cke_st, err_cmd
    );
endinterface

// File: rtl/mcb_sig_pipe.sv
// ---------------------------------------------------------------------------
// mcb_sig_pipe
// SDRAM command/address output stage. Latches the transaction address on
// mcb_bb, auto-increments the column by BL on c_rd/c_wr, encodes one-hot
// sequencer requests into a registered SDRAM command, and runs the CKE
// power-down / self-refresh state machine. Illegal requests set a sticky
// err_cmd flag.
// Ports:
//   mcb_clk  rising-edge clock
//   mcb_rst  asynchronous active-high reset
//   bus      mcb_sig_pipe_if.slave (requests in, SDRAM pins/status out)
// ---------------------------------------------------------------------------
module mcb_sig_pipe #(
    parameter int unsigned           MCB_B_W = 2,
    parameter int unsigned           MCB_R_W = 13,
    parameter int unsigned           MCB_C_W = 9,
    parameter int unsigned           SDR_B_W = 2,
    parameter int unsigned           SDR_A_W = 13,
    parameter int unsigned           AP_BIT  = 10,
    parameter int unsigned           BL      = 4,
    parameter logic [SDR_A_W-1:0]    MR_VAL  = 'h32,
    parameter logic [SDR_A_W-1:0]    EMR_VAL = 'h0
) (
    input  logic          mcb_clk,
    input  logic          mcb_rst,
    mcb_sig_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        CKE_ACT = 2'd0,
        CKE_PD  = 2'd1,
        CKE_SR  = 2'd2
    } cke_state_t;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_LMR = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_NOP = 4'b0111
    } sdr_cmd_t;

    cke_state_t         state_q;
    sdr_cmd_t           cmd_q;
    logic               cke_q;
    logic               err_q;
    logic [SDR_B_W-1:0] ba_q;
    logic [SDR_A_W-1:0] addr_q;

    logic [MCB_B_W-1:0] lat_ba;
    logic [MCB_R_W-1:0] lat_ra;
    logic [MCB_C_W-1:0] lat_ca;

    logic [14:0]        req;
    logic               any_req;
    logic               multi_req;
    logic               col_inc;
    logic [SDR_B_W-1:0] bank_ext;
    logic [SDR_A_W-1:0] row_ext;
    logic [SDR_A_W-1:0] col_ext;
    logic [SDR_A_W-1:0] col_ap_ext;

    assign req = {bus.i_prea, bus.i_ref, bus.i_lmr, bus.i_emr,
                  bus.c_ref, bus.c_act, bus.c_pre, bus.c_rda, bus.c_rd,
                  bus.c_wra, bus.c_wr, bus.c_pde, bus.c_pdx, bus.c_sre,
                  bus.c_srx};
    assign any_req   = |req;
    // Clearing the lowest set bit leaves something only if 2+ bits are set.
    assign multi_req = |(req & (req - 15'd1));
    // Only a legal, accepted read/write in ACT advances the column.
    assign col_inc   = !multi_req && (state_q == CKE_ACT) && (bus.c_rd || bus.c_wr);

    always_comb begin
        bank_ext               = '0;
        bank_ext[MCB_B_W-1:0]  = lat_ba;
        row_ext                = '0;
        row_ext[MCB_R_W-1:0]   = lat_ra;
        col_ext                = '0;
        col_ext[MCB_C_W-1:0]   = lat_ca;
        col_ap_ext             = col_ext;
        col_ap_ext[AP_BIT]     = 1'b1;
    end

    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            state_q <= CKE_ACT;
            cmd_q   <= CMD_NOP;
            cke_q   <= 1'b1;
            err_q   <= 1'b0;
            ba_q    <= '0;
            addr_q  <= '0;
            lat_ba  <= '0;
            lat_ra  <= '0;
            lat_ca  <= '0;
        end else if (!bus.mcb_sclr_n) begin
            state_q <= CKE_ACT;
            cmd_q   <= CMD_NOP;
            cke_q   <= 1'b1;
            err_q   <= 1'b0;
            ba_q    <= '0;
            addr_q  <= '0;
            lat_ba  <= '0;
            lat_ra  <= '0;
            lat_ca  <= '0;
        end else begin
            cmd_q  <= CMD_NOP;
            ba_q   <= '0;
            addr_q <= '0;

            if (bus.mcb_bb) begin
                lat_ba <= bus.mcb_ba;
                lat_ra <= bus.mcb_ra;
                lat_ca <= bus.mcb_ca;
            end else if (col_inc) begin
                lat_ca <= lat_ca + MCB_C_W'(BL);
            end

            if (multi_req) begin
                err_q <= 1'b1;
                cke_q <= (state_q == CKE_ACT);
            end else begin
                case (state_q)
                    CKE_ACT: begin
                        cke_q <= 1'b1;
                        if (bus.c_pde) begin
                            state_q <= CKE_PD;
                            cke_q   <= 1'b0;
                        end else if (bus.c_sre) begin
                            state_q <= CKE_SR;
                            cke_q   <= 1'b0;
                            cmd_q   <= CMD_REF;
                        end else if (bus.c_pdx || bus.c_srx) begin
                            err_q <= 1'b1;
                        end else if (bus.i_prea) begin
                            cmd_q  <= CMD_PRE;
                            addr_q <= '1;
                        end else if (bus.c_pre) begin
                            cmd_q <= CMD_PRE;
                            ba_q  <= bank_ext;
                        end else if (bus.i_ref || bus.c_ref) begin
                            cmd_q <= CMD_REF;
                        end else if (bus.i_lmr) begin
                            cmd_q  <= CMD_LMR;
                            addr_q <= MR_VAL;
                        end else if (bus.i_emr) begin
                            cmd_q  <= CMD_LMR;
                            ba_q   <= SDR_B_W'(1);
                            addr_q <= EMR_VAL;
                        end else if (bus.c_act) begin
                            cmd_q  <= CMD_ACT;
                            ba_q   <= bank_ext;
                            addr_q <= row_ext;
                        end else if (bus.c_rd || bus.c_rda) begin
                            cmd_q  <= CMD_RD;
                            ba_q   <= bank_ext;
                            addr_q <= bus.c_rda ? col_ap_ext : col_ext;
                        end else if (bus.c_wr || bus.c_wra) begin
                            cmd_q  <= CMD_WR;
                            ba_q   <= bank_ext;
                            addr_q <= bus.c_wra ? col_ap_ext : col_ext;
                        end
                    end
                    CKE_PD: begin
                        cke_q <= 1'b0;
                        if (bus.c_pdx) begin
                            state_q <= CKE_ACT;
                            cke_q   <= 1'b1;
                        end else if (any_req) begin
                            err_q <= 1'b1;
                        end
                    end
                    default: begin
                        cke_q <= 1'b0;
                        if (bus.c_srx) begin
                            state_q <= CKE_ACT;
                            cke_q   <= 1'b1;
                        end else if (any_req) begin
                            err_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.sdr_cke   = cke_q;
    assign bus.sdr_cs_n  = cmd_q[3];
    assign bus.sdr_ras_n = cmd_q[2];
    assign bus.sdr_cas_n = cmd_q[1];
    assign bus.sdr_we_n  = cmd_q[0];
    assign bus.sdr_ba    = ba_q;
    assign bus.sdr_addr  = addr_q;
    assign bus.cke_st    = state_q;
    assign bus.err_cmd   = err_q;

endmodule

// File: doc/mcb_sig_pipe.md
# mcb_sig_pipe

Parametrised SDRAM command/address output stage for the sdrc_lite memory controller back-end. It sits between the back-end command sequencer and the SDRAM pins. It latches the transaction address and auto-increments the column by a configurable burst length. It encodes one-hot sequencer requests into a registered SDRAM command/bank/address. It adds several functions:

- single-bank precharge;
- extended mode register load;
- a clock-enable (CKE) power-down/self-refresh state machine;
- sticky detection of illegal request combinations.

## Interface

Parameters:

- MCB_B_W, 2, back-end bank address width
- MCB_R_W, 13, back-end row address width
- MCB_C_W, 9, back-end column address width; must be ≤ AP_BIT
- SDR_B_W, 2, SDRAM bank pin width; must be ≥ MCB_B_W
- SDR_A_W, 13, SDRAM address pin width; must be ≥ MCB_R_W and > AP_BIT
- AP_BIT, 10, address bit carrying the auto-precharge / all-banks flag
- BL, 4, burst length; the column increment per non-auto-precharge read/write; power of two, 1–8
- MR_VAL, 13'h0032, mode register value driven on LMR
- EMR_VAL, 13'h0000, extended mode register value driven on LMR with BA = 1

Ports:

- mcb_clk  in  1  clock; all state on the rising edge
- mcb_rst  in  1  asynchronous, active-high reset
- mcb_sclr_n  in  1  synchronous clear, active low
- mcb_bb  in  1  begin-burst: latch mcb_ba/mcb_ra/mcb_ca
- mcb_ba  in  MCB_B_W  bank address
- mcb_ra  in  MCB_R_W  row address
- mcb_ca  in  MCB_C_W  start column
- i_prea, i_ref, i_lmr, i_emr  in  1 each  init requests: precharge-all, refresh, mode register, extended mode register
- c_ref, c_act, c_pre, c_rda, c_rd, c_wra, c_wr  in  1 each  run-time requests; c_pre precharges the latched bank only
- c_pde, c_pdx, c_sre, c_srx  in  1 each  power-down enter/exit, self-refresh enter/exit
- sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  out  1 each  SDRAM control pins
- sdr_ba  out  SDR_B_W  SDRAM bank
- sdr_addr  out  SDR_A_W  SDRAM address
- cke_st  out  2  CKE state: 0 = ACT, 1 = PD, 2 = SR
- err_cmd  out  1  sticky illegal-request flag

## Operation

- Command codes {cs_n, ras_n, cas_n, we_n}: LMR 0000, REF 0001, PRE 0010, ACT 0011, WR 0100, RD 0101, NOP 0111.
- The 15 request inputs form one request vector. Legal patterns are all-zero or exactly one bit set.

Address latch:

- On mcb_bb, load the bank, row and column registers.
- Otherwise, on c_rd or c_wr, column += BL, modulo 2^MCB_C_W (wraps inside the row).
- On c_rda, c_wra or anything else, hold.
- mcb_bb has priority over the increment.

Next-command decode (in ACT state):

- i_prea: PRE, ba 0, addr all-ones.
- c_pre: PRE, ba = latched bank, addr 0 (AP_BIT = 0).
- i_ref / c_ref: REF, ba 0, addr 0.
- i_lmr: LMR, ba 0, addr MR_VAL.
- i_emr: LMR, ba 1, addr EMR_VAL.
- c_act: ACT, ba = latched bank, addr = latched row, zero-extended.
- c_rd / c_rda: RD, ba = latched bank; addr = column zero-extended, with AP_BIT = 1 only for c_rda.
- c_wr / c_wra: WR, same address formation as reads.
- No request: NOP, ba 0, addr 0.

CKE state machine:

- ACT, c_pde: → PD; drive NOP with cke 0.
- ACT, c_sre: → SR; drive REF with cke 0.
- PD, c_pdx: → ACT; drive NOP with cke 1.
- SR, c_srx: → ACT; drive NOP with cke 1.
- In PD or SR, every other request (including no request): NOP, cke 0, state held.

Error flag:

- err_cmd is set when the request vector has two or more bits set. The command issued is then NOP, the latch does not increment, and the CKE state is unchanged.
- err_cmd is also set by any request other than the matching exit while in PD or SR. That request is ignored.
- err_cmd is also set by c_pdx or c_srx while in ACT.
- err_cmd clears only on reset or sclr.

## Timing

- All outputs are registered. A request sampled at edge N appears on the pins after edge N, one cycle of latency.
- The address used is the latch value before edge N. mcb_bb and a command in the same cycle use the old address.
- Reset and sclr (sclr has priority over all other logic):
  - command NOP, cke 1;
  - sdr_ba 0, sdr_addr 0;
  - latch registers 0;
  - cke_st ACT, err_cmd 0.
- Reset mid-power-down forces cke to 1 and state to ACT immediately (asynchronous).
- Back-to-back reads/writes are supported every cycle. The column increments on each c_rd/c_wr.

## Test plan

- Reset, then idle: pins = NOP, cke 1, ba 0, addr 0, err 0.
- mcb_bb with ba 2, ra 0x1ABC, ca 0x1F8; then c_act, c_rd, c_rd, c_rda on consecutive cycles:
  - ACT ba 2, addr 0x1ABC;
  - RD addr 0x1F8;
  - RD addr 0x1FC;
  - RD addr 0x400 (col 0x000 after wrap, AP bit set).
- i_prea → PRE, addr 0x1FFF.
- i_emr → LMR, ba 1, addr EMR_VAL.
- c_pre after mcb_bb with ba 3 → PRE, ba 3, addr 0.
- c_sre → REF with cke 0; two idle cycles → NOP, cke 0; c_act → ignored, err 1; c_srx → NOP, cke 1.
- c_rd and c_wr together → NOP, err 1, column unchanged; sclr_n low → err 0, all zeros.
- Assert mcb_rst while in PD → cke 1, cke_st 0 immediately, without waiting for a clock edge.
